// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 protocol monitor: taps a slave port, flags rule violations
// and keeps sticky/first-violation records plus transfer and violation counters.
module wb_protocol_monitor #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 26,
    parameter int unsigned PIPELINED = 0,
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           wb_cyc_i,
    input  logic                           wb_stb_i,
    input  logic                           wb_we_i,
    input  logic [AW-1:0]                  wb_adr_i,
    input  logic [DW/8-1:0]                wb_sel_i,
    input  logic [DW-1:0]                  wb_dat_i,
    input  logic                           wb_ack_o,
    input  logic                           wb_err_o,
    input  logic                           wb_rty_o,
    input  logic                           wb_stall_o,
    input  logic                           clr_i,
    output logic                           viol_pulse_o,
    output logic [7:0]                     viol_sticky_o,
    output logic [2:0]                     first_viol_o,
    output logic                           first_valid_o,
    output logic [CNT_W-1:0]               viol_cnt_o,
    output logic [CNT_W-1:0]               rd_cnt_o,
    output logic [CNT_W-1:0]               wr_cnt_o,
    output logic [$clog2(MAX_OUTST+1):0]   outst_o
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned OW   = $clog2(MAX_OUTST + 1) + 1;
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
    localparam bit          PIPE = (PIPELINED != 0);

    logic          term;
    logic          req;
    logic          accept;
    logic          held_now;
    logic          held_q;
    logic          cyc_q;
    logic          multi_term;
    logic          changed;
    logic          waiting;
    logic          wait_hit;
    logic          any_v;
    logic [7:0]    v;
    logic [2:0]    low_idx;
    logic [OW-1:0] outst_q;
    logic [OW-1:0] outst_nxt;
    logic [TW-1:0] wait_q;
    logic [TW-1:0] wait_nxt;
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] dat_q;

    // Bus qualifiers
    always_comb begin
        term       = wb_ack_o | wb_err_o | wb_rty_o;
        req        = wb_cyc_i & wb_stb_i;
        accept     = PIPE ? (req & ~wb_stall_o) : (req & wb_ack_o);
        held_now   = PIPE ? (req & wb_stall_o) : (req & ~term);
        multi_term = (wb_ack_o & wb_err_o) | (wb_ack_o & wb_rty_o) | (wb_err_o & wb_rty_o);
        changed    = (wb_adr_i != adr_q) | (wb_we_i != we_q) | (wb_sel_i != sel_q)
                   | (wb_we_i & (wb_dat_i != dat_q));
    end

    // Termination watchdog: restarts after each hit so the flag repeats every TIMEOUT cycles
    always_comb begin
        waiting  = wb_cyc_i & ~term &
                   (PIPE ? ((outst_q != '0) | (wb_stall_o & wb_stb_i)) : wb_stb_i);
        wait_hit = waiting & (wait_q == TW'(TIMEOUT - 1));
        wait_nxt = '0;
        if (waiting && !wait_hit) begin
            wait_nxt = wait_q + TW'(1);
        end
    end

    // Outstanding tracker, pipelined only; a simultaneous accept and term nets to zero
    always_comb begin
        outst_nxt = outst_q;
        if (!PIPE || !wb_cyc_i) begin
            outst_nxt = '0;
        end else if (accept && !term) begin
            if (outst_q < OW'(MAX_OUTST)) begin
                outst_nxt = outst_q + OW'(1);
            end
        end else if (term && !accept) begin
            if (outst_q != '0) begin
                outst_nxt = outst_q - OW'(1);
            end
        end
    end

    // Violation vector
    always_comb begin
        v    = '0;
        v[0] = wb_stb_i & ~wb_cyc_i;
        v[1] = term & ~wb_cyc_i;
        v[2] = multi_term;
        v[3] = held_q & req & changed;
        v[4] = wait_hit;
        v[5] = wb_cyc_i & term & (PIPE ? (outst_q == '0) : ~wb_stb_i);
        v[6] = PIPE & accept & ~term & (outst_q >= OW'(MAX_OUTST));
        v[7] = cyc_q & ~wb_cyc_i & (PIPE ? ((outst_q != '0) & ~term) : held_q);
        any_v = |v;
    end

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Protocol trackers; unaffected by clr_i
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            outst_q <= '0;
            wait_q  <= '0;
            held_q  <= 1'b0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            outst_q <= outst_nxt;
            wait_q  <= wait_nxt;
            held_q  <= held_now;
            cyc_q   <= wb_cyc_i;
            if (req) begin
                adr_q <= wb_adr_i;
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
        end
    end

    // Violation records; a violation coinciding with clr_i is kept as the new record
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            viol_pulse_o  <= 1'b0;
            viol_sticky_o <= '0;
            first_viol_o  <= '0;
            first_valid_o <= 1'b0;
            viol_cnt_o    <= '0;
        end else begin
            viol_pulse_o <= any_v;
            if (clr_i) begin
                viol_sticky_o <= v;
                viol_cnt_o    <= any_v ? CNT_W'(1) : '0;
                first_valid_o <= any_v;
                first_viol_o  <= any_v ? low_idx : 3'd0;
            end else if (any_v) begin
                viol_sticky_o <= viol_sticky_o | v;
                if (viol_cnt_o != '1) begin
                    viol_cnt_o <= viol_cnt_o + CNT_W'(1);
                end
                if (!first_valid_o) begin
                    first_viol_o  <= low_idx;
                    first_valid_o <= 1'b1;
                end
            end
        end
    end

    // Transfer counters; an accept in the clearing cycle counts as the first new transfer
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (clr_i) begin
            rd_cnt_o <= (accept && !wb_we_i) ? CNT_W'(1) : '0;
            wr_cnt_o <= (accept && wb_we_i) ? CNT_W'(1) : '0;
        end else if (accept) begin
            if (wb_we_i) begin
                wr_cnt_o <= wr_cnt_o + CNT_W'(1);
            end else begin
                rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            end
        end
    end

    assign outst_o = outst_q;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed bench for wb_protocol_monitor: a classic instance (TIMEOUT 8) and a
// pipelined instance (MAX_OUTST 4) observe the same bus nets.
module tb_wb_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, ack, err, rty, stall, clr;
    logic [25:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;

    logic        c_pulse, c_fvalid, p_pulse, p_fvalid;
    logic [7:0]  c_sticky, p_sticky;
    logic [2:0]  c_first, p_first;
    logic [15:0] c_vcnt, c_rd, c_wr, p_vcnt, p_rd, p_wr;
    logic [3:0]  c_outst, p_outst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_protocol_monitor #(.DW(32), .AW(26), .PIPELINED(0), .TIMEOUT(8), .MAX_OUTST(4), .CNT_W(16)) uc (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_ack_o(ack), .wb_err_o(err),
        .wb_rty_o(rty), .wb_stall_o(stall), .clr_i(clr), .viol_pulse_o(c_pulse),
        .viol_sticky_o(c_sticky), .first_viol_o(c_first), .first_valid_o(c_fvalid),
        .viol_cnt_o(c_vcnt), .rd_cnt_o(c_rd), .wr_cnt_o(c_wr), .outst_o(c_outst)
    );

    wb_protocol_monitor #(.DW(32), .AW(26), .PIPELINED(1), .TIMEOUT(16), .MAX_OUTST(4), .CNT_W(16)) up (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_ack_o(ack), .wb_err_o(err),
        .wb_rty_o(rty), .wb_stall_o(stall), .clr_i(clr), .viol_pulse_o(p_pulse),
        .viol_sticky_o(p_sticky), .first_viol_o(p_first), .first_valid_o(p_fvalid),
        .viol_cnt_o(p_vcnt), .rd_cnt_o(p_rd), .wr_cnt_o(p_wr), .outst_o(p_outst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0;
        stall = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        adr = 26'h0; sel = 4'hf; dat = 32'h0;
        repeat (2) tick();
        chk("rst_c_sticky", 32'(c_sticky), 32'h0);
        chk("rst_c_pulse", 32'(c_pulse), 32'h0);
        chk("rst_c_fvalid", 32'(c_fvalid), 32'h0);
        chk("rst_p_outst", 32'(p_outst), 32'h0);
        chk("rst_p_vcnt", 32'(p_vcnt), 32'h0);
        rst = 1'b0;
        tick();

        // Classic write, ack on the third cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 26'h100; dat = 32'ha5a5_0001;
        tick();
        tick();
        ack = 1'b1;
        tick();
        idle();
        tick();
        chk("wr_cnt", 32'(c_wr), 32'h1);
        chk("wr_rd_cnt", 32'(c_rd), 32'h0);
        chk("wr_sticky", 32'(c_sticky), 32'h0);
        chk("wr_outst", 32'(c_outst), 32'h0);

        // stb without cyc for one cycle
        stb = 1'b1;
        tick();
        chk("stbnc_pulse", 32'(c_pulse), 32'h1);
        chk("stbnc_sticky", 32'(c_sticky), 32'h01);
        chk("stbnc_first", 32'(c_first), 32'h0);
        chk("stbnc_fvalid", 32'(c_fvalid), 32'h1);
        chk("stbnc_vcnt", 32'(c_vcnt), 32'h1);
        stb = 1'b0;
        tick();
        chk("stbnc_pulse_end", 32'(c_pulse), 32'h0);
        chk("stbnc_vcnt_hold", 32'(c_vcnt), 32'h1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr1_sticky", 32'(c_sticky), 32'h0);
        chk("clr1_fvalid", 32'(c_fvalid), 32'h0);
        chk("clr1_wr", 32'(c_wr), 32'h0);

        // Held read, address changes, then timeout repeats every 8 cycles
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 26'h10;
        tick();
        adr = 26'h14;
        tick();
        chk("unstable_sticky", 32'(c_sticky), 32'h08);
        chk("unstable_first", 32'(c_first), 32'h3);
        chk("unstable_vcnt", 32'(c_vcnt), 32'h1);
        repeat (5) tick();
        chk("to_before_vcnt", 32'(c_vcnt), 32'h1);
        tick();
        chk("to1_sticky", 32'(c_sticky), 32'h18);
        chk("to1_vcnt", 32'(c_vcnt), 32'h2);
        chk("to1_pulse", 32'(c_pulse), 32'h1);
        chk("to1_first", 32'(c_first), 32'h3);
        repeat (7) tick();
        chk("to2_before_vcnt", 32'(c_vcnt), 32'h2);
        chk("to2_before_pulse", 32'(c_pulse), 32'h0);
        tick();
        chk("to2_vcnt", 32'(c_vcnt), 32'h3);
        ack = 1'b1;
        tick();
        chk("rd_cnt", 32'(c_rd), 32'h1);
        chk("rd_vcnt", 32'(c_vcnt), 32'h3);
        idle();
        tick();

        // ack and err together
        cyc = 1'b1; stb = 1'b1; ack = 1'b1; err = 1'b1;
        tick();
        chk("multi_sticky", 32'(c_sticky), 32'h1c);
        chk("multi_vcnt", 32'(c_vcnt), 32'h4);
        chk("multi_rd", 32'(c_rd), 32'h2);
        idle();
        tick();
        chk("idle_no_viol", 32'(c_vcnt), 32'h4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr2_sticky", 32'(c_sticky), 32'h0);
        chk("clr2_fvalid", 32'(c_fvalid), 32'h0);
        chk("clr2_rd", 32'(c_rd), 32'h0);
        chk("clr2_wr", 32'(c_wr), 32'h0);
        chk("clr2_vcnt", 32'(c_vcnt), 32'h0);

        // clr coinciding with an orphan termination
        stb = 1'b1;
        tick();
        chk("pre_orphan_sticky", 32'(c_sticky), 32'h01);
        stb = 1'b0; cyc = 1'b1; ack = 1'b1; clr = 1'b1;
        tick();
        chk("clr_orph_sticky", 32'(c_sticky), 32'h20);
        chk("clr_orph_vcnt", 32'(c_vcnt), 32'h1);
        chk("clr_orph_first", 32'(c_first), 32'h5);
        chk("clr_orph_fvalid", 32'(c_fvalid), 32'h1);
        idle();
        tick();

        // Pipelined: five accepts without ack, then cyc dropped
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("p_clr_sticky", 32'(p_sticky), 32'h0);
        chk("p_clr_outst", 32'(p_outst), 32'h0);
        cyc = 1'b1; stb = 1'b1;
        repeat (4) tick();
        chk("p_outst4", 32'(p_outst), 32'h4);
        chk("p_sticky4", 32'(p_sticky), 32'h0);
        tick();
        chk("p_ovf_sticky", 32'(p_sticky), 32'h40);
        chk("p_ovf_outst", 32'(p_outst), 32'h4);
        chk("p_ovf_first", 32'(p_first), 32'h6);
        chk("p_rd5", 32'(p_rd), 32'h5);
        chk("c_outst_zero", 32'(c_outst), 32'h0);
        idle();
        tick();
        chk("p_drop_sticky", 32'(p_sticky), 32'hc0);
        chk("p_drop_outst", 32'(p_outst), 32'h0);
        chk("p_drop_vcnt", 32'(p_vcnt), 32'h2);

        // Pipelined ack of a pending request, then an orphan ack
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cyc = 1'b1; stb = 1'b1;
        tick();
        chk("p_one_outst", 32'(p_outst), 32'h1);
        stb = 1'b0; ack = 1'b1;
        tick();
        chk("p_acked_outst", 32'(p_outst), 32'h0);
        chk("p_acked_sticky", 32'(p_sticky), 32'h0);
        tick();
        chk("p_orphan_sticky", 32'(p_sticky), 32'h20);
        idle();
        tick();

        // Asynchronous reset mid-burst
        cyc = 1'b1; stb = 1'b1;
        repeat (2) tick();
        chk("p_burst_outst", 32'(p_outst), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_p_outst", 32'(p_outst), 32'h0);
        chk("arst_p_rd", 32'(p_rd), 32'h0);
        chk("arst_p_sticky", 32'(p_sticky), 32'h0);
        chk("arst_p_fvalid", 32'(p_fvalid), 32'h0);
        chk("arst_c_sticky", 32'(c_sticky), 32'h0);
        chk("arst_c_vcnt", 32'(c_vcnt), 32'h0);
        idle();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_pulse", 32'(c_pulse), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
